tc_wl_dispatch: RTL and testbench

- Parametrised successor to the thread-controller FSM.
- Accepts a work-list descriptor (base, length) from the signal network and fetches the list line-by-line through the L1-to-MRA request/response path.
- Unpacks each line into fixed-width entries and dispatches them round-robin to NUM_CORES worker cores (PF/SIMD) over per-core valid/ready.
- Reports completion to the signal network once every entry is dispatched and all cores are idle.

---
 rtl/tc_wl_dispatch.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_tc_wl_dispatch.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_wl_dispatch.sv
// tc_wl_dispatch: work-list fetch and round-robin dispatch controller.
// Takes a (base, length) descriptor from the signal network and fetches the
// list one line at a time over the MRA request/response path. Each line is
// split into entries, and entries go out one per cycle to the worker cores in
// round-robin order. Completion is signalled once every entry has been handed
// out and all cores are idle.
// Optional build macro: TC_WL_PERF_EN adds saturating performance counters
// (perf_cycles, perf_mra_stall, perf_core_stall).
module tc_wl_dispatch #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int WL_LEN_BITS     = 32,
    parameter int ENTRY_WIDTH     = 64,
    parameter int NUM_CORES       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sn_start_valid,
    output logic                   sn_start_ready,
    input  logic [ADDR_WIDTH-1:0]  sn_wl_base,
    input  logic [WL_LEN_BITS-1:0] sn_wl_len,
    output logic                   sn_done,
    output logic [WL_LEN_BITS-1:0] sn_done_count,
    output logic                   mra_req_valid,
    input  logic                   mra_req_ready,
    output logic [ADDR_WIDTH-1:0]  mra_req_addr,
    input  logic                   mra_rsp_valid,
    input  logic [DATA_WIDTH-1:0]  mra_rsp_data,
    output logic [NUM_CORES-1:0]   core_valid,
    input  logic [NUM_CORES-1:0]   core_ready,
    output logic [ENTRY_WIDTH-1:0] core_entry,
    input  logic [NUM_CORES-1:0]   core_busy,
    output logic                   busy
`ifdef TC_WL_PERF_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_mra_stall,
    output logic [31:0]            perf_core_stall
`endif
);

    localparam int LB       = DATA_WIDTH / 8;
    localparam int LB_BITS  = $clog2(LB);
    localparam int EPL      = DATA_WIDTH / ENTRY_WIDTH;
    localparam int EPL_BITS = $clog2(EPL);
    localparam int E_W      = (EPL_BITS > 0) ? EPL_BITS : 1;
    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int RR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [WL_LEN_BITS-1:0] len_q, len_d;
    logic [WL_LEN_BITS-1:0] nl_q, nl_d;
    logic [WL_LEN_BITS-1:0] lines_req_q, lines_req_d;
    logic [WL_LEN_BITS-1:0] done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0]       in_flight_q, in_flight_d;
    logic [CNT_W-1:0]       buf_cnt_q, buf_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [E_W-1:0]         e_q, e_d;
    logic [RR_W-1:0]        rr_q, rr_d;

    logic [DATA_WIDTH-1:0]  line_mem [MAX_OUTSTANDING];

    logic                   start_acc;
    logic [WL_LEN_BITS-1:0] wl_rem;
    logic [WL_LEN_BITS-1:0] nl_start;
    logic [CNT_W-1:0]       credits;
    logic                   req_fire;
    logic                   have_line;
    logic [DATA_WIDTH-1:0]  head_line;
    logic                   grant_found;
    logic [RR_W-1:0]        grant_idx;
    logic                   xfer;
    logic                   last_entry;
    logic                   pop;

    // Line count rounded up without an adder that could overflow near the max length.
    assign wl_rem   = sn_wl_len & WL_LEN_BITS'(EPL - 1);
    assign nl_start = (sn_wl_len >> EPL_BITS) + {{(WL_LEN_BITS-1){1'b0}}, (wl_rem != '0)};

    // Every request or buffered line holds one credit until its line is popped.
    assign credits  = CNT_W'(MAX_OUTSTANDING) - (in_flight_q + buf_cnt_q);

    // Address depends only on registered state, so it stays put while the request waits.
    assign mra_req_valid = (state_q == S_FETCH) && (lines_req_q != nl_q) && (credits != '0);
    assign mra_req_addr  = base_q + (ADDR_WIDTH'(lines_req_q) << LB_BITS);
    assign req_fire      = mra_req_valid && mra_req_ready;

    assign have_line  = (buf_cnt_q != '0) && ((state_q == S_FETCH) || (state_q == S_DRAIN));
    assign head_line  = line_mem[rd_ptr_q];

    // Round-robin search: first ready core at or after rr_q, wrapping around.
    always_comb begin
        int c;
        c           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            c = int'(rr_q) + k;
            if (c >= NUM_CORES) begin
                c = c - NUM_CORES;
            end
            if (!grant_found && core_ready[c]) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(c);
            end
        end
    end

    assign xfer       = have_line && grant_found;
    assign core_valid = xfer ? (NUM_CORES'(1) << grant_idx) : '0;
    assign core_entry = have_line ? head_line[e_q*ENTRY_WIDTH +: ENTRY_WIDTH] : '0;

    // The final entry of the list pops its line even if the line is only partly used.
    assign last_entry = (done_cnt_q == (len_q - WL_LEN_BITS'(1)));
    assign pop        = xfer && ((e_q == E_W'(EPL - 1)) || last_entry);

    assign sn_start_ready = (state_q == S_IDLE);
    assign sn_done        = (state_q == S_DONE);
    assign sn_done_count  = done_cnt_q;
    assign busy           = (state_q != S_IDLE);

    // FSM next state and descriptor capture.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sn_start_valid) begin
                    start_acc = 1'b1;
                    state_d   = (sn_wl_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (lines_req_q == nl_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((done_cnt_q == len_q) && (buf_cnt_q == '0) && (core_busy == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next-state: descriptor, request counter, buffer bookkeeping, dispatch.
    always_comb begin
        base_d      = base_q;
        len_d       = len_q;
        nl_d        = nl_q;
        lines_req_d = lines_req_q;
        done_cnt_d  = done_cnt_q;
        in_flight_d = in_flight_q;
        buf_cnt_d   = buf_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        e_d         = e_q;
        rr_d        = rr_q;

        if (start_acc) begin
            base_d      = {sn_wl_base[ADDR_WIDTH-1:LB_BITS], {LB_BITS{1'b0}}};
            len_d       = sn_wl_len;
            nl_d        = nl_start;
            lines_req_d = '0;
            done_cnt_d  = '0;
            e_d         = '0;
        end

        if (req_fire) begin
            lines_req_d = lines_req_q + WL_LEN_BITS'(1);
        end

        case ({req_fire, mra_rsp_valid})
            2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
            default: in_flight_d = in_flight_q;
        endcase

        case ({mra_rsp_valid, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + CNT_W'(1);
            2'b01:   buf_cnt_d = buf_cnt_q - CNT_W'(1);
            default: buf_cnt_d = buf_cnt_q;
        endcase

        if (mra_rsp_valid) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        if (xfer) begin
            done_cnt_d = done_cnt_q + WL_LEN_BITS'(1);
            e_d        = pop ? '0 : e_q + E_W'(1);
            rr_d       = (grant_idx == RR_W'(NUM_CORES - 1)) ? '0 : grant_idx + RR_W'(1);
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            nl_q        <= '0;
            lines_req_q <= '0;
            done_cnt_q  <= '0;
            in_flight_q <= '0;
            buf_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            e_q         <= '0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            nl_q        <= nl_d;
            lines_req_q <= lines_req_d;
            done_cnt_q  <= done_cnt_d;
            in_flight_q <= in_flight_d;
            buf_cnt_q   <= buf_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            e_q         <= e_d;
            rr_q        <= rr_d;
        end
    end

    // Line storage; emptiness is tracked by the counters, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (mra_rsp_valid) begin
            line_mem[wr_ptr_q] <= mra_rsp_data;
        end
    end

    // A response must always belong to an outstanding request.
    rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        mra_rsp_valid |-> (in_flight_q != '0));

`ifdef TC_WL_PERF_EN
    logic [31:0] perf_cycles_q, perf_mra_stall_q, perf_core_stall_q;

    // Saturating event counters, cleared when a new descriptor is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q     <= '0;
            perf_mra_stall_q  <= '0;
            perf_core_stall_q <= '0;
        end else if (start_acc) begin
            perf_cycles_q     <= '0;
            perf_mra_stall_q  <= '0;
            perf_core_stall_q <= '0;
        end else begin
            if (busy && !(&perf_cycles_q)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (mra_req_valid && !mra_req_ready && !(&perf_mra_stall_q)) begin
                perf_mra_stall_q <= perf_mra_stall_q + 32'd1;
            end
            if (have_line && (core_ready == '0) && !(&perf_core_stall_q)) begin
                perf_core_stall_q <= perf_core_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles     = perf_cycles_q;
    assign perf_mra_stall  = perf_mra_stall_q;
    assign perf_core_stall = perf_core_stall_q;
`endif

endmodule

// File: tb/tb_tc_wl_dispatch.sv
// Testbench for tc_wl_dispatch: MRA responder model plus dispatch scoreboard.
// Expected entries are queued when a response line is driven and compared when
// a core accepts an entry; the expected grantee comes from a round-robin model.
module tb_tc_wl_dispatch;

    localparam int AW  = 64;
    localparam int DW  = 512;
    localparam int LW  = 32;
    localparam int EW  = 64;
    localparam int NC  = 4;
    localparam int MO  = 4;
    localparam int EPL = DW / EW;
    localparam int LB  = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sn_start_valid = 1'b0;
    logic          sn_start_ready;
    logic [AW-1:0] sn_wl_base = '0;
    logic [LW-1:0] sn_wl_len = '0;
    logic          sn_done;
    logic [LW-1:0] sn_done_count;
    logic          mra_req_valid;
    logic          mra_req_ready = 1'b1;
    logic [AW-1:0] mra_req_addr;
    logic          mra_rsp_valid;
    logic [DW-1:0] mra_rsp_data;
    logic [NC-1:0] core_valid;
    logic [NC-1:0] core_ready = '1;
    logic [EW-1:0] core_entry;
    logic [NC-1:0] core_busy = '0;
    logic          busy;

    tc_wl_dispatch #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WL_LEN_BITS(LW),
        .ENTRY_WIDTH(EW), .NUM_CORES(NC), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sn_start_valid(sn_start_valid), .sn_start_ready(sn_start_ready),
        .sn_wl_base(sn_wl_base), .sn_wl_len(sn_wl_len),
        .sn_done(sn_done), .sn_done_count(sn_done_count),
        .mra_req_valid(mra_req_valid), .mra_req_ready(mra_req_ready),
        .mra_req_addr(mra_req_addr),
        .mra_rsp_valid(mra_rsp_valid), .mra_rsp_data(mra_rsp_data),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_entry(core_entry), .core_busy(core_busy), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [AW-1:0] a, input int k);
        return {a[47:0], 16'(k)} ^ 64'hC0DE_0000_0000_0000;
    endfunction

    // Job description shared with the responder model.
    logic [AW-1:0] job_base = '0;
    int            job_len  = 0;
    bit            rand_mode = 1'b0;

    // Responder / scoreboard state (written only by the bfm process).
    logic [AW-1:0] rsp_q[$];
    logic [EW-1:0] exp_q[$];
    int req_idx = 0, rsp_line = 0, ent_idx = 0;
    int lines_acc = 0, lines_done = 0, occ_max = 0, viol = 0, rr_m = 0;
    int per_core[NC];
    bit            hold_pend = 1'b0;
    logic [AW-1:0] hold_addr = '0;

    // MRA responder and dispatch scoreboard: sample at negedge, drive after posedge.
    initial begin : bfm
        int g;
        int c;
        int occ;
        logic [AW-1:0] a;
        mra_rsp_valid = 1'b0;
        mra_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rsp_q.delete(); exp_q.delete();
                req_idx = 0; rsp_line = 0; ent_idx = 0; lines_acc = 0; lines_done = 0;
                rr_m = 0; hold_pend = 1'b0;
            end else begin
                if (sn_start_valid && sn_start_ready) begin
                    req_idx = 0; rsp_line = 0; ent_idx = 0; lines_acc = 0; lines_done = 0;
                    occ_max = 0; viol = 0;
                    for (int i = 0; i < NC; i++) per_core[i] = 0;
                end
                if (hold_pend && !(mra_req_valid && (mra_req_addr == hold_addr))) viol++;
                hold_pend = mra_req_valid && !mra_req_ready;
                hold_addr = mra_req_addr;
                if (mra_req_valid && mra_req_ready) begin
                    check("req_addr", mra_req_addr, job_base + AW'(req_idx) * AW'(LB));
                    $display("REQ  idx=%0d addr=%0h", req_idx, mra_req_addr);
                    req_idx++;
                    lines_acc++;
                    rsp_q.push_back(mra_req_addr);
                    occ = lines_acc - lines_done;
                    if (occ > occ_max) occ_max = occ;
                end
                if ((core_valid & ~core_ready) != '0) viol++;
                if ((core_valid & core_ready) != '0) begin
                    g = -1;
                    for (int k = 0; k < NC; k++) begin
                        c = (rr_m + k) % NC;
                        if (g < 0 && core_ready[c]) g = c;
                    end
                    check("disp_core", 64'(core_valid), 64'(1) << g);
                    if (exp_q.size() == 0) begin
                        check("disp_unexpected", 64'(core_entry), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("disp_entry", core_entry, exp_q.pop_front());
                    end
                    $display("DISP n=%0d core_valid=%b entry=%0h", ent_idx, core_valid, core_entry);
                    per_core[g]++;
                    rr_m = (g + 1) % NC;
                    ent_idx++;
                    if ((ent_idx % EPL) == 0 || ent_idx == job_len) lines_done++;
                end
            end
            @(posedge clk);
            #1;
            mra_rsp_valid = 1'b0;
            if (rst_n && rsp_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
                a = rsp_q.pop_front();
                for (int k = 0; k < EPL; k++) begin
                    mra_rsp_data[k*EW +: EW] = ent(a, k);
                    if (rsp_line * EPL + k < job_len) exp_q.push_back(ent(a, k));
                end
                rsp_line++;
                mra_rsp_valid = 1'b1;
            end
        end
    end

    // Random backpressure on the MRA and core ready lines when enabled.
    initial begin : rand_drv
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                mra_req_ready = 1'($urandom_range(0, 1));
                core_ready    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
        end
    end

    task automatic start_job(input logic [AW-1:0] b, input int l);
        job_base = b;
        job_len  = l;
        @(posedge clk);
        #1;
        sn_wl_base     = b;
        sn_wl_len      = LW'(l);
        sn_start_valid = 1'b1;
        @(posedge clk);
        #1;
        sn_start_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        while (cyc < bound && !got) begin
            @(negedge clk);
            cyc++;
            if (sn_done) got = 1'b1;
        end
        if (!got) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin : main
        int cyc;
        int hi;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 64'(sn_start_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req_valid", 64'(mra_req_valid), 64'(0));
        check("rst_core_valid", 64'(core_valid), 64'(0));
        check("rst_done", 64'(sn_done), 64'(0));
        rst_n = 1'b1;

        // len = 0: immediate done pulse, no requests.
        start_job(64'h1000, 0);
        wait_done("t1", 20, cyc);
        check("t1_latency", 64'(cyc), 64'(1));
        check("t1_count", 64'(sn_done_count), 64'(0));
        @(negedge clk);
        check("t1_pulse_width", 64'(sn_done), 64'(0));
        check("t1_no_req", 64'(lines_acc), 64'(0));

        // len = 20, all ready: three lines, partial last line.
        start_job(64'h2000, 20);
        wait_done("t2", 500, cyc);
        check("t2_lines", 64'(lines_acc), 64'(3));
        check("t2_count", 64'(sn_done_count), 64'(20));
        check("t2_disp", 64'(ent_idx), 64'(20));
        check("t2_exp_empty", 64'(exp_q.size()), 64'(0));
        check("t2_core0", 64'(per_core[0]), 64'(5));

        // len = 64 with 10-cycle request stall, then random backpressure.
        mra_req_ready = 1'b0;
        start_job(64'h3000, 64);
        repeat (10) @(negedge clk);
        check("t3_stall_valid", 64'(mra_req_valid), 64'(1));
        check("t3_stall_addr", mra_req_addr, 64'h3000);
        rand_mode = 1'b1;
        wait_done("t3", 4000, cyc);
        @(posedge clk);
        #1;
        rand_mode = 1'b0;
        mra_req_ready = 1'b1;
        core_ready = '1;
        check("t3_count", 64'(sn_done_count), 64'(64));
        check("t3_lines", 64'(lines_acc), 64'(8));
        check("t3_viol", 64'(viol), 64'(0));
        check("t3_occ_le_max", 64'(occ_max <= MO), 64'(1));

        // Fixed ready mask 0101: only cores 0 and 2 receive entries.
        @(posedge clk);
        #1;
        core_ready = 4'b0101;
        start_job(64'h4000, 8);
        wait_done("t4", 500, cyc);
        check("t4_viol", 64'(viol), 64'(0));
        check("t4_core0", 64'(per_core[0]), 64'(4));
        check("t4_core1", 64'(per_core[1]), 64'(0));
        check("t4_core2", 64'(per_core[2]), 64'(4));
        check("t4_core3", 64'(per_core[3]), 64'(0));

        // core_busy[1] held after the last dispatch delays completion.
        @(posedge clk);
        #1;
        core_ready = '1;
        core_busy  = 4'b0010;
        start_job(64'h6000, 4);
        cyc = 0;
        while (ent_idx < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_disp", 64'(ent_idx), 64'(4));
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (sn_done) hi++;
        end
        check("t5_held", 64'(hi), 64'(0));
        @(posedge clk);
        #1;
        core_busy = '0;
        wait_done("t5", 20, cyc);
        check("t5_latency", 64'(cyc), 64'(2));
        check("t5_count", 64'(sn_done_count), 64'(4));

        // Reset in the middle of FETCH after two of four requests.
        @(posedge clk);
        #1;
        core_ready    = '0;
        mra_req_ready = 1'b0;
        start_job(64'h7000, 32);
        cyc = 0;
        while (lines_acc < 2 && cyc < 100) begin
            mra_req_ready = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        mra_req_ready = 1'b0;
        check("t6_two_req", 64'(lines_acc), 64'(2));
        rst_n = 1'b0;
        #1;
        check("t6_rst_start_ready", 64'(sn_start_ready), 64'(1));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_req", 64'(mra_req_valid), 64'(0));
        check("t6_rst_addr", mra_req_addr, 64'h0);
        check("t6_rst_core", 64'(core_valid), 64'(0));
        check("t6_rst_entry", core_entry, 64'h0);
        check("t6_rst_count", 64'(sn_done_count), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        core_ready = '1;
        mra_req_ready = 1'b1;
        start_job(64'h5000, 12);
        wait_done("t6", 500, cyc);
        check("t6_lines", 64'(lines_acc), 64'(2));
        check("t6_count", 64'(sn_done_count), 64'(12));
        check("t6_exp_empty", 64'(exp_q.size()), 64'(0));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
